// File: rtl/int_to_fp_pipe.sv
// Three-stage elastic integer-to-IEEE-754 converter: capture/abs, normalise, round/pack.
// Each stage holds a valid bit; a stage loads when empty or when its contents move on.
module int_to_fp_pipe #(
  parameter int unsigned INT_W = 64,
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 52
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INT_W-1:0]         in_int,
  input  logic                     in_signed,
  input  logic [2:0]               in_rm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_fp,
  output logic                     out_inexact
);

  localparam int unsigned FpW  = 1 + EXP_W + MAN_W;
  localparam int unsigned LzcW = $clog2(INT_W + 1);
  localparam int unsigned EW   = $clog2(INT_W);
  // Wide enough to always have a guard bit and at least one sticky bit.
  localparam int unsigned ExtW = (INT_W > MAN_W + 3) ? INT_W : MAN_W + 3;
  localparam int unsigned PadW = ExtW - INT_W;
  localparam logic [EXP_W-1:0] Bias = {1'b0, {(EXP_W-1){1'b1}}};

  localparam logic [2:0] RmRtz = 3'd1;
  localparam logic [2:0] RmRdn = 3'd2;
  localparam logic [2:0] RmRup = 3'd3;
  localparam logic [2:0] RmRmm = 3'd4;

  function automatic logic [LzcW-1:0] count_lz(input logic [INT_W-1:0] v);
    count_lz = LzcW'(INT_W);
    for (int i = 0; i < INT_W; i++) begin
      if (v[i]) count_lz = LzcW'(INT_W - 1 - i);
    end
  endfunction

  logic adv1, adv2, adv3, ld1, ld2, ld3;

  logic             v1_q, v1_d, sign1_q, sign1_d;
  logic [INT_W-1:0] mag1_q, mag1_d;
  logic [2:0]       rm1_q, rm1_d;

  logic             v2_q, v2_d, sign2_q, sign2_d, zero2_q, zero2_d;
  logic [INT_W-1:0] norm2_q, norm2_d;
  logic [EW-1:0]    e2_q, e2_d;
  logic [2:0]       rm2_q, rm2_d;

  logic             v3_q, v3_d, inexact3_q, inexact3_d;
  logic [FpW-1:0]   fp3_q, fp3_d;

  logic             sign_in;
  logic [INT_W-1:0] mag_in;
  logic [LzcW-1:0]  lzc_val;
  logic [ExtW-1:0]  ext;
  logic [MAN_W:0]   kept;
  logic             guard, sticky, inexact, inc, carry, unused_hidden;
  logic [MAN_W-1:0] man_r;
  logic [EXP_W-1:0] exp_r;

  // Ready ripples back from the output through each stage's valid bit.
  always_comb begin
    adv3     = !v3_q | out_ready;
    adv2     = !v2_q | adv3;
    adv1     = !v1_q | adv2;
    ld1      = adv1 & in_valid;
    ld2      = adv2 & v1_q;
    ld3      = adv3 & v2_q;
  end

  assign in_ready    = adv1;
  assign out_valid   = v3_q;
  assign out_fp      = fp3_q;
  assign out_inexact = inexact3_q;

  // S1: sign and magnitude; the signed minimum negates to itself, i.e. 2^(INT_W-1).
  always_comb begin
    sign_in = in_signed & in_int[INT_W-1];
    mag_in  = sign_in ? (~in_int) + INT_W'(1) : in_int;
    v1_d    = adv1 ? in_valid : v1_q;
    sign1_d = ld1 ? sign_in : sign1_q;
    mag1_d  = ld1 ? mag_in : mag1_q;
    rm1_d   = ld1 ? in_rm : rm1_q;
  end

  // S2: normalise so the leading one sits at bit INT_W-1.
  always_comb begin
    lzc_val = count_lz(mag1_q);
    v2_d    = adv2 ? v1_q : v2_q;
    sign2_d = ld2 ? sign1_q : sign2_q;
    rm2_d   = ld2 ? rm1_q : rm2_q;
    zero2_d = ld2 ? (mag1_q == '0) : zero2_q;
    norm2_d = ld2 ? (mag1_q << lzc_val) : norm2_q;
    e2_d    = ld2 ? EW'(INT_W - 1) - EW'(lzc_val) : e2_q;
  end

  // S3: round to MAN_W+1 significant bits and pack.
  always_comb begin
    ext     = ExtW'(norm2_q) << PadW;
    kept    = ext[ExtW-1 -: MAN_W+1];
    guard   = ext[ExtW-MAN_W-2];
    sticky  = |ext[ExtW-MAN_W-3:0];
    inexact = guard | sticky;
    unique case (rm2_q)
      RmRtz:   inc = 1'b0;
      RmRdn:   inc = sign2_q & inexact;
      RmRup:   inc = !sign2_q & inexact;
      RmRmm:   inc = guard;
      default: inc = guard & (sticky | kept[0]);
    endcase
    {carry, unused_hidden, man_r} = {1'b0, kept} + {{(MAN_W+1){1'b0}}, inc};
    if (carry) man_r = '0;
    exp_r = EXP_W'(e2_q) + EXP_W'(carry) + Bias;

    v3_d       = adv3 ? v2_q : v3_q;
    fp3_d      = fp3_q;
    inexact3_d = inexact3_q;
    if (ld3) begin
      fp3_d      = zero2_q ? '0 : {sign2_q, exp_r, man_r};
      inexact3_d = !zero2_q & inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q       <= 1'b0;
      sign1_q    <= 1'b0;
      mag1_q     <= '0;
      rm1_q      <= '0;
      v2_q       <= 1'b0;
      sign2_q    <= 1'b0;
      zero2_q    <= 1'b0;
      norm2_q    <= '0;
      e2_q       <= '0;
      rm2_q      <= '0;
      v3_q       <= 1'b0;
      fp3_q      <= '0;
      inexact3_q <= 1'b0;
    end else begin
      v1_q       <= v1_d;
      sign1_q    <= sign1_d;
      mag1_q     <= mag1_d;
      rm1_q      <= rm1_d;
      v2_q       <= v2_d;
      sign2_q    <= sign2_d;
      zero2_q    <= zero2_d;
      norm2_q    <= norm2_d;
      e2_q       <= e2_d;
      rm2_q      <= rm2_d;
      v3_q       <= v3_d;
      fp3_q      <= fp3_d;
      inexact3_q <= inexact3_d;
    end
  end

endmodule
